// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: steps FETCH/DECODE/EXECUTE/MEM/WB, owns the
// imem/dmem handshakes, a bus watchdog, the illegal-instruction trap and retire count.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             r_type,
  input  logic             i_type,
  input  logic             store,
  input  logic             load,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic             lui,
  input  logic             auipc,
  input  logic             branch_out,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_en,
  output logic             reg_write_en,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JAL    = 3'd4,
    C_JALR   = 3'd5
  } class_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  state_e            state_q, state_d;
  class_e            cls_q, cls_d;
  logic [1:0]        cause_q, cause_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0]  retired_q;
  logic              wdog_hit;
  logic              wcnt_inc;
  logic              any_class;

  assign wdog_hit  = (wcnt_q == WCNT_MAX);
  assign any_class = load | store | branch | jal | jalr | lui | auipc | r_type | i_type;
  assign wcnt_inc  = ((state_q == S_FETCH) && run && !imem_ack) ||
                     ((state_q == S_MEM) && !dmem_ack);

  // State register plus the registered class latch and trap cause
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_ALU;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic; an ack in the expiry cycle takes precedence over the watchdog
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          if (imem_ack) begin
            state_d = S_DECODE;
          end else if (wdog_hit) begin
            state_d = S_TRAP;
            cause_d = CAUSE_IMEM;
          end
        end
      end
      S_DECODE: begin
        if (load)        cls_d = C_LOAD;
        else if (store)  cls_d = C_STORE;
        else if (branch) cls_d = C_BRANCH;
        else if (jal)    cls_d = C_JAL;
        else if (jalr)   cls_d = C_JALR;
        else             cls_d = C_ALU;
        if (any_class) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        if ((cls_q == C_LOAD) || (cls_q == C_STORE)) state_d = S_MEM;
        else if (cls_q == C_BRANCH)                  state_d = S_FETCH;
        else                                         state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        end else if (wdog_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobe decode from current state and same-cycle inputs
  always_comb begin
    imem_req     = 1'b0;
    ir_en        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 2'd0;
    trap         = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = run;
        ir_en    = run & imem_ack;
      end
      S_EXECUTE: begin
        if (cls_q == C_BRANCH) begin
          pc_en  = 1'b1;
          pc_sel = branch_out ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ack && (cls_q == C_STORE)) pc_en = 1'b1;
      end
      S_WB: begin
        reg_write_en = 1'b1;
        pc_en        = 1'b1;
        if (cls_q == C_JAL)       pc_sel = 2'd2;
        else if (cls_q == C_JALR) pc_sel = 2'd3;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  // Watchdog: counts stalled FETCH/MEM cycles, cleared by ack or any state change
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
    end else if ((state_d != state_q) || !wcnt_inc) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_q + WCNT_W'(1);
    end
  end

  // Retired-instruction counter, one tick per PC update
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (pc_en) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against a phase/latency model of the sequencer.
module tb_multicycle_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 32;

  localparam int K_ALU    = 0;
  localparam int K_LOAD   = 1;
  localparam int K_STORE  = 2;
  localparam int K_BRANCH = 3;
  localparam int K_JAL    = 4;
  localparam int K_JALR   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             branch_out;
  logic             imem_ack;
  logic             dmem_ack;
  logic [8:0]       fl;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_en;
  logic             reg_write_en;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic [2:0]       state;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .r_type       (fl[1]),
    .i_type       (fl[0]),
    .store        (fl[7]),
    .load         (fl[8]),
    .branch       (fl[6]),
    .jal          (fl[5]),
    .jalr         (fl[4]),
    .lui          (fl[3]),
    .auipc        (fl[2]),
    .branch_out   (branch_out),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .ir_en        (ir_en),
    .reg_write_en (reg_write_en),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .state        (state),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .retired      (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {imem_req, ir_en, dmem_req, dmem_we, reg_write_en, pc_en};
  endfunction

  // Highest set flag defines the class; lower-priority flags are random noise
  function automatic logic [8:0] make_flags(input int kind);
    logic [8:0] r;
    r = 9'($urandom);
    case (kind)
      K_LOAD:   return {1'b1, r[7:0]};
      K_STORE:  return {2'b01, r[6:0]};
      K_BRANCH: return {3'b001, r[5:0]};
      K_JAL:    return {4'b0001, r[4:0]};
      K_JALR:   return {5'b00001, r[3:0]};
      default:  return {5'b00000, (r[3:0] == 4'd0) ? 4'b0010 : r[3:0]};
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; fl = '0; branch_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
  endtask

  // One instruction: imem acked after iw stall cycles, dmem after dw stall cycles
  task automatic run_instr(input int kind, input logic [8:0] fv, input int iw, input int dw,
                           input logic bout);
    int   exp_st[$];
    int   lat, k, st_err, n_ireq, n_ir, n_dreq, n_dwe, n_rwe, n_trap;
    int   e_dreq, e_dwe, e_rwe;
    logic done;
    logic mem;
    logic [1:0] sel_at_pc, e_sel;
    mem = (kind == K_LOAD) || (kind == K_STORE);
    for (int i = 0; i <= iw; i++) exp_st.push_back(0);
    exp_st.push_back(1);
    exp_st.push_back(2);
    if (mem) for (int i = 0; i <= dw; i++) exp_st.push_back(3);
    if (kind != K_STORE && kind != K_BRANCH) exp_st.push_back(4);
    lat = exp_st.size();
    k = 0; st_err = 0; n_ireq = 0; n_ir = 0; n_dreq = 0; n_dwe = 0; n_rwe = 0; n_trap = 0;
    done = 1'b0; sel_at_pc = 2'd0;
    while (!done && k < 64) begin
      @(negedge clk);
      run = 1'b1; fl = fv; branch_out = bout; imem_ack = 1'b0; dmem_ack = 1'b0;
      #1;
      imem_ack = (imem_req === 1'b1) && (n_ireq == iw);
      dmem_ack = (dmem_req === 1'b1) && (n_dreq == dw);
      #1;
      if (k >= lat || state !== 3'(exp_st[k])) st_err++;
      if (imem_req === 1'b1) n_ireq++;
      if (ir_en === 1'b1) n_ir++;
      if (dmem_req === 1'b1) n_dreq++;
      if (dmem_we === 1'b1) n_dwe++;
      if (reg_write_en === 1'b1) n_rwe++;
      if (trap !== 1'b0) n_trap++;
      if (pc_en === 1'b1) begin
        done = 1'b1;
        sel_at_pc = pc_sel;
      end
      k++;
    end
    e_dreq = mem ? dw + 1 : 0;
    e_dwe  = (kind == K_STORE) ? dw + 1 : 0;
    e_rwe  = (kind == K_STORE || kind == K_BRANCH) ? 0 : 1;
    e_sel  = (kind == K_BRANCH) ? {1'b0, bout} :
             (kind == K_JAL)    ? 2'd2 :
             (kind == K_JALR)   ? 2'd3 : 2'd0;
    check("instr_done",   32'(done), 32'd1);
    check("latency",      32'(k), 32'(lat));
    check("state_trace",  32'(st_err), 32'd0);
    check("imem_req_cyc", 32'(n_ireq), 32'(iw + 1));
    check("ir_en_cyc",    32'(n_ir), 32'd1);
    check("dmem_req_cyc", 32'(n_dreq), 32'(e_dreq));
    check("dmem_we_cyc",  32'(n_dwe), 32'(e_dwe));
    check("reg_we_cyc",   32'(n_rwe), 32'(e_rwe));
    check("pc_sel",       32'(sel_at_pc), 32'(e_sel));
    check("no_trap",      32'(n_trap), 32'd0);
    exp_retired = exp_retired + CNT_W'(1);
    @(posedge clk);
    #1;
    check("retired", 32'(retired), 32'(exp_retired));
  endtask

  initial begin
    int   err_cnt;
    int   kind, iw, dw;
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; fl = '0; branch_out = 1'b0;
    exp_retired = '0;

    do_reset();
    #1;
    check("rst_state",   32'(state), 32'd0);
    check("rst_trap",    32'(trap), 32'd0);
    check("rst_cause",   32'(trap_cause), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_strobes", 32'(strobes()), 32'd0);

    // run=0 idles in FETCH well past the timeout without requesting or trapping
    err_cnt = 0;
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      @(negedge clk);
      run = 1'b0; imem_ack = 1'($urandom);
      #1;
      if (state !== 3'd0 || imem_req !== 1'b0 || ir_en !== 1'b0 || trap !== 1'b0) err_cnt++;
    end
    check("run0_hold", 32'(err_cnt), 32'd0);
    imem_ack = 1'b0;

    // Directed instructions
    run_instr(K_ALU,    9'b000000010, 0, 0, 1'b0);
    run_instr(K_BRANCH, 9'b001000000, 0, 0, 1'b1);
    run_instr(K_BRANCH, 9'b001000000, 0, 0, 1'b0);
    run_instr(K_LOAD,   9'b100000000, 0, 3, 1'b0);
    run_instr(K_STORE,  9'b010000000, 0, 0, 1'b0);
    run_instr(K_STORE,  9'b010000000, 2, 2, 1'b0);
    run_instr(K_JAL,    9'b000110000, 0, 0, 1'b0);
    run_instr(K_JALR,   9'b000010000, 1, 0, 1'b0);
    run_instr(K_ALU,    9'b000001000, TIMEOUT - 1, 0, 1'b0);
    run_instr(K_LOAD,   9'b111111111, 0, TIMEOUT - 1, 1'b1);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      iw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : int'($urandom_range(0, 2));
      dw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : int'($urandom_range(0, 2));
      run_instr(kind, make_flags(kind), iw, dw, 1'($urandom));
    end

    // imem never acks: TIMEOUT FETCH cycles, then TRAP with cause 2
    err_cnt = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
      #1;
      if (state !== 3'd0 || imem_req !== 1'b1) err_cnt++;
    end
    check("imem_wait_fetch", 32'(err_cnt), 32'd0);
    @(negedge clk);
    #1;
    check("imem_to_state",   32'(state), 32'd5);
    check("imem_to_trap",    32'(trap), 32'd1);
    check("imem_to_cause",   32'(trap_cause), 32'd2);
    check("imem_to_strobes", 32'(strobes()), 32'd0);
    check("imem_to_retired", 32'(retired), 32'(exp_retired));

    // dmem never acks on a load: TIMEOUT MEM cycles, then TRAP with cause 3
    do_reset();
    err_cnt = 0;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      @(negedge clk);
      run = 1'b1; fl = 9'b100000000; imem_ack = (k == 1); dmem_ack = 1'b0;
      #1;
      if (k >= 4 && k < TIMEOUT + 4 &&
          (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0)) err_cnt++;
    end
    check("dmem_wait_mem",   32'(err_cnt), 32'd0);
    check("dmem_to_state",   32'(state), 32'd5);
    check("dmem_to_cause",   32'(trap_cause), 32'd3);
    check("dmem_to_strobes", 32'(strobes()), 32'd0);

    // Illegal instruction: no class flag in DECODE
    do_reset();
    @(negedge clk);
    run = 1'b1; fl = '0; imem_ack = 1'b1;
    #1;
    check("ill_ir_en", 32'(ir_en), 32'd1);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    check("ill_decode", 32'(state), 32'd1);
    @(negedge clk);
    #1;
    check("ill_state", 32'(state), 32'd5);
    check("ill_trap",  32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd1);
    err_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1; fl = 9'h1FF;
      #1;
      if (state !== 3'd5 || trap !== 1'b1 || strobes() !== 6'd0) err_cnt++;
    end
    check("trap_sticky",      32'(err_cnt), 32'd0);
    check("trap_cause_first", 32'(trap_cause), 32'd1);

    // Reset out of TRAP after retiring something
    do_reset();
    run_instr(K_ALU, 9'b000000001, 0, 0, 1'b0);
    @(negedge clk);
    run = 1'b1; fl = '0; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_trap",    32'(trap), 32'd1);
    check("pre_rst_retired", 32'(retired), 32'd1);
    do_reset();
    #1;
    check("post_rst_state",   32'(state), 32'd0);
    check("post_rst_trap",    32'(trap), 32'd0);
    check("post_rst_retired", 32'(retired), 32'd0);
    check("post_rst_cause",   32'(trap_cause), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, driving the IR, PC, register-file write and data-memory strobes from the decoder's type flags. It also owns the instruction/data memory req/ack handshakes, a bus-timeout watchdog, an illegal-instruction trap and a retired-instruction counter. It sits between the fetch unit, the decode stage and the memory interfaces.

Parameters:
TIMEOUT, 16, maximum wait cycles for imem_ack/dmem_ack before trapping (must be >=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
run  input  1  allow new fetches; sampled in FETCH only
r_type, i_type, store, load, branch, jal, jalr, lui, auipc  input  1 each  decoded class flags
branch_out  input  1  branch-taken from comparator
imem_req  output  1  instruction fetch request
imem_ack  input  1  instruction valid this cycle
dmem_req  output  1  data access request
dmem_we  output  1  data write (store) qualifier
dmem_ack  input  1  data access complete
ir_en  output  1  load instruction register
reg_write_en  output  1  register-file write strobe
pc_en  output  1  PC update strobe
pc_sel  output  2  0=PC+4, 1=branch target, 2=JAL target, 3=JALR target
state  output  3  0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WB, 5 TRAP
trap  output  1  trap state active
trap_cause  output  2  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout
retired  output  CNT_W  instructions retired

Behaviour:
- Reset (sync, clk edge with rst=1): state=FETCH; wait counter, class latch, retired, trap_cause cleared. All strobes 0. Reset overrides everything, including TRAP and a pending req; in-flight acks are discarded.
- Strobes decode from state plus the named inputs, in the same cycle (Mealy where noted). All strobes are 0 in any state not listed.
- FETCH:
  - imem_req = run.
  - ir_en = run & imem_ack.
  - On run & imem_ack: go to DECODE.
  - run=0: hold, wait counter held at 0.
- DECODE (1 cycle): latch class with priority load>store>branch>jal>jalr>lui/auipc/r_type/i_type.
  - No flag set: go to TRAP, cause=1.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - load/store: go to MEM.
  - branch: pc_en=1, pc_sel = branch_out ? 1 : 0, retire, go to FETCH.
  - Others: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 iff latched class is store.
  - On dmem_ack:
    - store: pc_en=1, pc_sel=0, retire, go to FETCH.
    - load: go to WB.
- WB (1 cycle): reg_write_en=1, pc_en=1, retire, go to FETCH.
  - pc_sel = 2 for jal, 3 for jalr, else 0.
- Retire: retired increments by 1 in the cycle pc_en=1. It wraps modulo 2^CNT_W.
- Watchdog:
  - Counts cycles in FETCH (with run=1) and in MEM without ack.
  - Clears on ack and on every state change.
  - When the count reaches TIMEOUT-1 with no ack in that cycle: go to TRAP, cause=2 (FETCH) or 3 (MEM).
  - An ack in the same cycle as expiry wins; no trap.
- TRAP: trap=1, all strobes 0, stays until rst. trap_cause holds the first cause.
- Acks outside FETCH/MEM are ignored. Class flags and branch_out are don't-care outside DECODE/EXECUTE.
- Latency, zero-wait memory (ack in first req cycle):
  - ALU/U-type/JAL/JALR: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
- Reset, run=1, imem_ack=1 at first req, r_type=1 -> states 0,1,2,4,0. reg_write_en and pc_en high in WB, pc_sel=0, retired=1.
- Branch with branch_out=1, then one with branch_out=0 -> pc_en in EXECUTE with pc_sel 1 then 0. No reg_write_en. retired=2 after both.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with reg_write_en=1. A store in the same flow shows dmem_we=1 and no WB.
- TIMEOUT=16, imem_ack never asserted -> TRAP after 16 FETCH cycles, trap_cause=2, strobes 0. Repeat with ack on cycle 16 -> no trap.
- All class flags 0 in DECODE -> TRAP, trap_cause=1. Mid-TRAP rst -> state=0, trap=0, retired=0 next cycle.
- jalr=1 with jal=1 simultaneously -> jal priority, pc_sel=2. run=0 in FETCH -> imem_req=0, state held, no timeout.
